// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults, also used by decode and writeback.
package regfile_pkg;

  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned ZERO_REG  = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: write ports, read ports and the dump stream.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = $clog2(DEF_DEPTH),
  parameter int NR = 2,
  parameter int NW = 1
);

  logic [NW-1:0]         we;
  logic [NW-1:0][AW-1:0] waddr;
  logic [NW-1:0][DW-1:0] wdata;
  logic [NR-1:0]         re;
  logic [NR-1:0][AW-1:0] raddr;
  logic [NR-1:0][DW-1:0] rdata;

  logic          dump_start;
  logic          dump_abort;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_busy;
  logic          dump_done;

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata,
    input  dump_start, dump_abort, dump_ready,
    output dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata,
    output dump_start, dump_abort, dump_ready,
    input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

endinterface

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks every register index, snapshots it in LOAD and holds
// the beat in SEND until the consumer accepts it.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          ready_i,
  input  logic [DW-1:0] rd_data_i,
  output logic [AW-1:0] rd_addr_o,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          busy_o,
  output logic          done_o
);

  // One extra index bit so the counter never wraps back onto register 0.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  dump_state_t   state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          addr_d  = idx_q[AW-1:0];
          data_d  = rd_data_i;
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort takes priority over a same-cycle handshake.
        if (abort_i) begin
          state_d = IDLE;
        end else if (ready_i) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + (AW+1)'(1);
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr_o = idx_q[AW-1:0];
  assign valid_o   = (state_q == SEND);
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass on every read port
// and a handshaked dump engine for debug/sampling.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NR    = 2,
  parameter int NW    = 1
) (
  input logic       clk,
  input logic       rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] regs_q, regs_d;
  logic [NW-1:0]            we;
  logic [NW-1:0][AW-1:0]    waddr;
  logic [NW-1:0][DW-1:0]    wdata;
  logic [NR-1:0][DW-1:0]    rdata;
  logic [AW-1:0]            dump_raddr;
  logic [DW-1:0]            dump_rdata;

  assign we    = bus.we;
  assign waddr = bus.waddr;
  assign wdata = bus.wdata;

  // Array value overridden by the highest-index write port hitting the
  // same address this cycle; register 0 is hardwired to zero.
  function automatic logic [DW-1:0] rd_mux(
    input logic [AW-1:0]            a,
    input logic [DEPTH-1:0][DW-1:0] arr,
    input logic [NW-1:0]            w_en,
    input logic [NW-1:0][AW-1:0]    w_a,
    input logic [NW-1:0][DW-1:0]    w_d
  );
    logic [DW-1:0] v;
    v = arr[a];
    for (int i = 0; i < NW; i++)
      if (w_en[i] && w_a[i] == a) v = w_d[i];
    if (a == AW'(ZERO_REG)) v = '0;
    return v;
  endfunction

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NW; i++)
      if (we[i] && waddr[i] != AW'(ZERO_REG)) regs_d[waddr[i]] = wdata[i];
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    assign rdata[j] = (rst || !bus.re[j]) ? '0
                    : rd_mux(bus.raddr[j], regs_q, we, waddr, wdata);
  end

  assign bus.rdata  = rdata;
  assign dump_rdata = rd_mux(dump_raddr, regs_q, we, waddr, wdata);

  regfile_dump_fsm #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .start_i   (bus.dump_start),
    .abort_i   (bus.dump_abort),
    .ready_i   (bus.dump_ready),
    .rd_data_i (dump_rdata),
    .rd_addr_o (dump_raddr),
    .valid_o   (bus.dump_valid),
    .addr_o    (bus.dump_addr),
    .data_o    (bus.dump_data),
    .busy_o    (bus.dump_busy),
    .done_o    (bus.dump_done)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports.
module tb_regfile_mp;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [15:0] sh [16];

  regfile_mp_if #(.DW(16), .AW(4), .NR(2), .NW(2)) rf ();

  regfile_mp #(.DW(16), .DEPTH(16), .NR(2), .NW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a full dump; optionally stalls on one beat (writing that register
  // meanwhile) or aborts on one beat.
  task automatic dump_run(input int stall_at, input int abort_at);
    int n, dones;
    bit fin, seen_done;
    logic [15:0] old;
    n = 0; dones = 0; fin = 0; seen_done = 0;
    rf.dump_ready = 1'b1;
    rf.dump_start = 1'b1;
    step();
    rf.dump_start = 1'b0;
    chk("dump_busy_start", rf.dump_busy, 1);
    for (int c = 0; c < 200 && !fin; c++) begin
      if (seen_done) begin
        chk("dump_busy_fall", rf.dump_busy, 0);
        fin = 1;
      end else begin
        if (rf.dump_done) begin dones++; seen_done = 1; end
        if (rf.dump_valid) begin
          chk("beat_addr", rf.dump_addr, n);
          chk("beat_data", rf.dump_data, sh[n]);
          if (n == abort_at) begin
            rf.dump_abort = 1'b1;
            step();
            rf.dump_abort = 1'b0;
            chk("abort_valid", rf.dump_valid, 0);
            chk("abort_busy", rf.dump_busy, 0);
            for (int k = 0; k < 40; k++) begin
              if (rf.dump_done) dones++;
              step();
            end
            chk("abort_no_done", dones, 0);
            fin = 1;
          end else if (n == stall_at) begin
            old = sh[n];
            rf.dump_ready = 1'b0;
            rf.dump_start = 1'b1;
            rf.we = 2'b01; rf.waddr[0] = 4'(n); rf.wdata[0] = 16'hDEAD;
            for (int k = 0; k < 5; k++) begin
              step();
              rf.we = 2'b00;
              rf.dump_start = 1'b0;
              chk("stall_valid", rf.dump_valid, 1);
              chk("stall_addr", rf.dump_addr, n);
              chk("stall_data", rf.dump_data, old);
            end
            sh[n] = 16'hDEAD;
            rf.re = 2'b01; rf.raddr[0] = 4'(n);
            #1 chk("stall_rd_new", rf.rdata[0], 16'hDEAD);
            rf.re = 2'b00;
            rf.dump_ready = 1'b1;
            n++;
          end else begin
            n++;
          end
        end
      end
      if (!fin) step();
    end
    chk("dump_finished", fin, 1);
    if (abort_at < 0) begin
      chk("dump_beats", n, 16);
      chk("dump_dones", dones, 1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    rf.we = '0; rf.waddr = '0; rf.wdata = '0;
    rf.re = '0; rf.raddr = '0;
    rf.dump_start = 1'b0; rf.dump_abort = 1'b0; rf.dump_ready = 1'b0;
    step(); step();
    rf.re = 2'b11; rf.raddr[0] = 4'd5; rf.raddr[1] = 4'd3;
    #1;
    chk("rst_rd0", rf.rdata[0], 0);
    chk("rst_busy", rf.dump_busy, 0);
    chk("rst_valid", rf.dump_valid, 0);
    chk("rst_done", rf.dump_done, 0);
    chk("rst_daddr", rf.dump_addr, 0);
    chk("rst_ddata", rf.dump_data, 0);
    rst = 1'b0;
    step();

    // write r5 on port0, drop a write to r0 on port1
    rf.we = 2'b11;
    rf.waddr[0] = 4'd5; rf.wdata[0] = 16'hA5A5;
    rf.waddr[1] = 4'd0; rf.wdata[1] = 16'hFFFF;
    step();
    rf.we = 2'b00;
    rf.re = 2'b11; rf.raddr[0] = 4'd5; rf.raddr[1] = 4'd5;
    #1;
    chk("r5_p0", rf.rdata[0], 16'hA5A5);
    chk("r5_p1", rf.rdata[1], 16'hA5A5);
    rf.raddr[1] = 4'd0;
    #1 chk("r0_zero", rf.rdata[1], 0);

    // both write ports hit r3: port1 wins for bypass and storage
    rf.we = 2'b11;
    rf.waddr[0] = 4'd3; rf.wdata[0] = 16'h1111;
    rf.waddr[1] = 4'd3; rf.wdata[1] = 16'h2222;
    rf.raddr[0] = 4'd3;
    #1 chk("r3_bypass", rf.rdata[0], 16'h2222);
    step();
    rf.we = 2'b00;
    #1 chk("r3_stored", rf.rdata[0], 16'h2222);

    // same-cycle bypass and re gating
    rf.we = 2'b01; rf.waddr[0] = 4'd7; rf.wdata[0] = 16'hBEEF;
    rf.raddr[0] = 4'd7; rf.re = 2'b01;
    #1 chk("r7_bypass", rf.rdata[0], 16'hBEEF);
    rf.re = 2'b00;
    #1 chk("r7_re0", rf.rdata[0], 0);
    rf.we = 2'b00;
    step();

    // r1..r15 = i*0101
    sh[0] = 16'h0000;
    for (int i = 1; i < 16; i++) begin
      sh[i] = 16'(i * 16'h0101);
      rf.we = 2'b01; rf.waddr[0] = 4'(i); rf.wdata[0] = sh[i];
      step();
    end
    rf.we = 2'b00;
    rf.re = 2'b10; rf.raddr[1] = 4'd15;
    #1 chk("r15_p1", rf.rdata[1], 16'h0F0F);
    rf.re = 2'b00;

    dump_run(-1, -1);
    step();
    dump_run(4, -1);
    step();
    dump_run(-1, 8);

    // async reset mid-dump
    rf.dump_ready = 1'b0;
    rf.dump_start = 1'b1;
    step();
    rf.dump_start = 1'b0;
    step(); step();
    chk("pre_rst_busy", rf.dump_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", rf.dump_busy, 0);
    chk("arst_valid", rf.dump_valid, 0);
    chk("arst_daddr", rf.dump_addr, 0);
    #1 rst = 1'b0;
    rf.re = 2'b11; rf.raddr[0] = 4'd15; rf.raddr[1] = 4'd4;
    #1;
    chk("arst_r15", rf.rdata[0], 0);
    chk("arst_r4", rf.rdata[1], 0);
    step();
    chk("post_busy", rf.dump_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
